// File: rtl/sensor_arbiter.sv
// Round-robin arbiter: acknowledges one data_parser at a time and streams its 272-bit record as a byte frame.
// Define SENSOR_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
module sensor_arbiter #(
   parameter int NUM_SENSORS = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                       clk_72MHz,
   input  logic                       rst_n,
   input  logic [NUM_SENSORS-1:0]     sensor_data_avl,
   input  logic [272*NUM_SENSORS-1:0] sensor_iterations,
   output logic [NUM_SENSORS-1:0]     reset_parser,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       busy,
   output logic                       ack_timeout
);

   localparam logic [5:0] LAST_BYTE = 6'd33;
   localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 1);
   localparam logic [2:0] LAST_INIT = 3'(NUM_SENSORS - 1);

   typedef enum logic [2:0] {IDLE, ACK, SEND_HDR, SEND_DATA, SEND_CSUM} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             grant_q, grant_d;
   logic [2:0]             last_q, last_d;
   logic [271:0]           data_q, data_d;
   logic [NUM_SENSORS-1:0] rp_q, rp_d;
   logic [7:0]             txd_q, txd_d;
   logic                   txv_q, txv_d;
   logic                   busy_q, busy_d;
   logic                   to_q, to_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [5:0]             idx_q, idx_d;
`ifdef SENSOR_ARB_CHECKSUM_EN
   logic [7:0]             csum_q, csum_d;
`endif

   logic                   found_hi, found_lo, req_found;
   logic [2:0]             sel_hi, sel_lo, req_sel;
   logic [NUM_SENSORS-1:0] req_onehot;
   logic [271:0]           req_slice;
   logic                   avl_g, xfer;

   function automatic logic [7:0] byte_at(input logic [271:0] d, input logic [5:0] i);
      logic [8:0] base;
      base = (9'd33 - {3'b000, i}) * 9'd8;
      return d[base +: 8];
   endfunction

   // Round-robin: first requester above last_grant wins, otherwise the lowest requester at or below it.
   always_comb begin
      found_hi   = 1'b0;
      found_lo   = 1'b0;
      sel_hi     = '0;
      sel_lo     = '0;
      req_onehot = '0;
      req_slice  = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (sensor_data_avl[i] && (3'(i) > last_q) && !found_hi) begin
            found_hi = 1'b1;
            sel_hi   = 3'(i);
         end
         if (sensor_data_avl[i] && (3'(i) <= last_q) && !found_lo) begin
            found_lo = 1'b1;
            sel_lo   = 3'(i);
         end
      end
      req_found = found_hi | found_lo;
      req_sel   = found_hi ? sel_hi : sel_lo;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (req_sel == 3'(i)) begin
            req_onehot[i] = 1'b1;
            req_slice     = sensor_iterations[272*i +: 272];
         end
      end
   end

   assign avl_g = |(sensor_data_avl & rp_q);
   assign xfer  = txv_q & tx_ready;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      data_d  = data_q;
      rp_d    = rp_q;
      txd_d   = txd_q;
      txv_d   = txv_q;
      to_d    = 1'b0;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
`ifdef SENSOR_ARB_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_found) begin
               state_d = ACK;
               grant_d = req_sel;
               last_d  = req_sel;
               data_d  = req_slice;
               rp_d    = req_onehot;
               cnt_d   = '0;
            end
         end
         ACK: begin
            cnt_d = cnt_q + 8'd1;
            if (!avl_g) begin
               rp_d    = '0;
               state_d = SEND_HDR;
            end else if (cnt_q == ACK_LIMIT) begin
               rp_d    = '0;
               to_d    = 1'b1;
               state_d = SEND_HDR;
            end
         end
         SEND_HDR: begin
            // First cycle here loads the header; the next byte follows on the transfer edge.
            if (!txv_q) begin
               txv_d  = 1'b1;
               txd_d  = {4'hA, 1'b0, grant_q};
`ifdef SENSOR_ARB_CHECKSUM_EN
               csum_d = '0;
`endif
            end else if (xfer) begin
               state_d = SEND_DATA;
               idx_d   = '0;
               txd_d   = byte_at(data_q, 6'd0);
`ifdef SENSOR_ARB_CHECKSUM_EN
               csum_d  = csum_q ^ txd_q;
`endif
            end
         end
         SEND_DATA: begin
            if (xfer) begin
               if (idx_q == LAST_BYTE) begin
`ifdef SENSOR_ARB_CHECKSUM_EN
                  state_d = SEND_CSUM;
                  txd_d   = csum_q ^ txd_q;
`else
                  state_d = IDLE;
                  txv_d   = 1'b0;
                  txd_d   = '0;
`endif
               end else begin
                  idx_d  = idx_q + 6'd1;
                  txd_d  = byte_at(data_q, idx_q + 6'd1);
`ifdef SENSOR_ARB_CHECKSUM_EN
                  csum_d = csum_q ^ txd_q;
`endif
               end
            end
         end
`ifdef SENSOR_ARB_CHECKSUM_EN
         SEND_CSUM: begin
            if (xfer) begin
               state_d = IDLE;
               txv_d   = 1'b0;
               txd_d   = '0;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            rp_d    = '0;
            txv_d   = 1'b0;
            txd_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_72MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_INIT;
         data_q  <= '0;
         rp_q    <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
`ifdef SENSOR_ARB_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         data_q  <= data_d;
         rp_q    <= rp_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         busy_q  <= busy_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
`ifdef SENSOR_ARB_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign reset_parser = rp_q;
   assign tx_data      = txd_q;
   assign tx_valid     = txv_q;
   assign busy         = busy_q;
   assign ack_timeout  = to_q;

endmodule

// File: tb/tb_sensor_arbiter.sv
// Directed bench for sensor_arbiter: arbitration order, acknowledge handshake/timeout, frame bytes, reset abort.
module tb_sensor_arbiter;

   localparam int N = 4;
`ifdef SENSOR_ARB_CHECKSUM_EN
   localparam int FLEN = 36;
`else
   localparam int FLEN = 35;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     avl;
   logic [272*N-1:0] iters;
   logic [N-1:0]     rp;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic             ack_to;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sensor_arbiter dut (
      .clk_72MHz        (clk),
      .rst_n            (rst_n),
      .sensor_data_avl  (avl),
      .sensor_iterations(iters),
      .reset_parser     (rp),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .busy             (busy),
      .ack_timeout      (ack_to)
   );

   task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Byte k of the frame payload (k=0 sent first) is base + step*k.
   function automatic logic [271:0] pat(input logic [7:0] base, input logic [7:0] step);
      logic [271:0] r;
      r = '0;
      for (int k = 0; k < 34; k++) r = {r[263:0], 8'(int'(base) + int'(step) * k)};
      return r;
   endfunction

   task automatic set_slice(input int s, input logic [271:0] v);
      iters[272*s +: 272] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_grant(output logic [N-1:0] g);
      int cyc;
      g = '0;
      cyc = 0;
      while (g == '0 && cyc < 400) begin
         @(negedge clk);
         #1;
         cyc++;
         g = rp;
      end
   endtask

   task automatic hold_ack(input int s, input bit drop, output int hi, output int lat, output int tos);
      hi  = rp[s] ? 1 : 0;
      tos = ack_to ? 1 : 0;
      lat = 0;
      tx_ready = 1'b0;
      while (!tx_valid && lat < 400) begin
         @(negedge clk);
         #1;
         lat++;
         if (drop && lat == 1) avl[s] = 1'b0;
         if (rp[s]) hi++;
         if (ack_to) tos++;
      end
   endtask

   task automatic get_frame(input int mode, input int maxb, output logic [7:0] hdr,
                            output logic [271:0] dat, output logic [7:0] csum,
                            output int nb, output int stab, output int rps);
      int         cyc;
      logic       pend;
      logic [7:0] pd;
      hdr = '0; dat = '0; csum = '0; nb = 0; stab = 0; rps = 0;
      cyc = 0; pend = 1'b0; pd = '0;
      while (nb < maxb && cyc < 400) begin
         @(negedge clk);
         cyc++;
         tx_ready = (mode == 0) ? 1'b1 : cyc[0];
         #1;
         if (rp != '0) rps++;
         if (pend && (!tx_valid || tx_data !== pd)) stab++;
         pend = 1'b0;
         if (tx_valid && tx_ready) begin
            if (nb == 0) hdr = tx_data;
            else if (nb <= 34) dat = {dat[263:0], tx_data};
            else csum = tx_data;
            nb++;
         end else if (tx_valid) begin
            pend = 1'b1;
            pd   = tx_data;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] g;
      logic [7:0]   hdr, csum, ecs;
      logic [271:0] dat, exp_d;
      int           hi, lat, tos, nb, stab, rps, es;

      rst_n = 1'b0; avl = '0; iters = '0; tx_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rp", 272'(rp), 272'(0));
      chk("rst_valid", 272'(tx_valid), 272'(0));
      chk("rst_data", 272'(tx_data), 272'(0));
      chk("rst_busy", 272'(busy), 272'(0));
      chk("rst_to", 272'(ack_to), 272'(0));
      rst_n = 1'b1;

      // Single sensor 2, acknowledge dropped one cycle after it is seen
      for (int s = 0; s < N; s++) set_slice(s, pat(8'(16 * (s + 1)), 8'h01));
      set_slice(2, pat(8'h01, 8'h01));
      @(negedge clk);
      avl[2] = 1'b1;
      wait_grant(g);
      chk("s2_grant", 272'(g), 272'(4'b0100));
      hold_ack(2, 1'b1, hi, lat, tos);
      chk("s2_ack_len", 272'(hi), 272'(2));
      chk("s2_hdr_latency", 272'(lat), 272'(3));
      chk("s2_no_timeout", 272'(tos), 272'(0));
      chk("s2_busy", 272'(busy), 272'(1));
      get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("s2_hdr", 272'(hdr), 272'(8'hA2));
      chk("s2_data", dat, pat(8'h01, 8'h01));
      chk("s2_nbytes", 272'(nb), 272'(FLEN));
      @(negedge clk);
      #1;
      chk("s2_end_valid", 272'(tx_valid), 272'(0));
      chk("s2_end_busy", 272'(busy), 272'(0));

      // All four requesting, no acknowledge drop: strict rotation with timeouts
      avl = '0;
      do_reset();
      for (int s = 0; s < N; s++) set_slice(s, pat(8'(16 * (s + 1)), 8'h01));
      avl = 4'hF;
      for (int f = 0; f < 5; f++) begin
         es = f % N;
         wait_grant(g);
         chk("rr_grant", 272'(g), 272'(4'b0001 << es));
         hold_ack(es, 1'b0, hi, lat, tos);
         chk("rr_ack_len", 272'(hi), 272'(255));
         chk("rr_timeout_pulse", 272'(tos), 272'(1));
         get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
         chk("rr_hdr", 272'(hdr), 272'(8'hA0 | 8'(es)));
         chk("rr_data", dat, pat(8'(16 * (es + 1)), 8'h01));
      end

      // Back-pressure: tx_ready toggles every cycle
      avl = '0;
      do_reset();
      set_slice(1, pat(8'hC3, 8'h07));
      avl[1] = 1'b1;
      wait_grant(g);
      chk("bp_grant", 272'(g), 272'(4'b0010));
      hold_ack(1, 1'b1, hi, lat, tos);
      get_frame(1, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("bp_hdr", 272'(hdr), 272'(8'hA1));
      chk("bp_data", dat, pat(8'hC3, 8'h07));
      chk("bp_nbytes", 272'(nb), 272'(FLEN));
      chk("bp_stable", 272'(stab), 272'(0));
`ifdef SENSOR_ARB_CHECKSUM_EN
      exp_d = pat(8'hC3, 8'h07);
      ecs = 8'hA1;
      for (int k = 0; k < 34; k++) ecs = ecs ^ exp_d[8*k +: 8];
      chk("bp_csum", 272'(csum), 272'(ecs));

      avl = '0;
      do_reset();
      set_slice(1, pat(8'h5A, 8'h00));
      avl[1] = 1'b1;
      wait_grant(g);
      hold_ack(1, 1'b1, hi, lat, tos);
      get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("cs_hdr", 272'(hdr), 272'(8'hA1));
      chk("cs_csum", 272'(csum), 272'(8'hA1));
`endif

      // Reset during data byte 10, avl[3] kept high
      avl = '0;
      do_reset();
      set_slice(3, pat(8'h80, 8'h02));
      avl[3] = 1'b1;
      wait_grant(g);
      chk("ra_grant", 272'(g), 272'(4'b1000));
      hold_ack(3, 1'b1, hi, lat, tos);
      avl[3] = 1'b1;
      get_frame(0, 11, hdr, dat, csum, nb, stab, rps);
      chk("ra_partial", 272'(nb), 272'(11));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ra_async_valid", 272'(tx_valid), 272'(0));
      chk("ra_async_rp", 272'(rp), 272'(0));
      chk("ra_async_busy", 272'(busy), 272'(0));
      @(negedge clk);
      #1;
      chk("ra_held_valid", 272'(tx_valid), 272'(0));
      rst_n = 1'b1;
      wait_grant(g);
      chk("ra_regrant", 272'(g), 272'(4'b1000));
      hold_ack(3, 1'b1, hi, lat, tos);
      get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("ra_hdr", 272'(hdr), 272'(8'hA3));
      chk("ra_data", dat, pat(8'h80, 8'h02));

      // Late request during a sensor-0 frame; source data changes after the grant
      avl = '0;
      do_reset();
      set_slice(0, pat(8'h30, 8'h03));
      set_slice(1, pat(8'h66, 8'h05));
      avl[0] = 1'b1;
      wait_grant(g);
      chk("lr_grant0", 272'(g), 272'(4'b0001));
      hold_ack(0, 1'b1, hi, lat, tos);
      avl[1] = 1'b1;
      set_slice(0, '1);
      get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("lr_hdr0", 272'(hdr), 272'(8'hA0));
      chk("lr_data0_latched", dat, pat(8'h30, 8'h03));
      chk("lr_no_rp_in_frame", 272'(rps), 272'(0));
      wait_grant(g);
      chk("lr_grant1", 272'(g), 272'(4'b0010));
      hold_ack(1, 1'b1, hi, lat, tos);
      get_frame(0, FLEN, hdr, dat, csum, nb, stab, rps);
      chk("lr_hdr1", 272'(hdr), 272'(8'hA1));
      chk("lr_data1", dat, pat(8'h66, 8'h05));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
